// File: rtl/rope_pkg.sv
// Shared constants and types for the rope collision slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rope_pkg;
    localparam int ROPES       = 6;
    localparam int LOCK_FRAMES = 4;
    localparam int SPEED_W     = 32;

    typedef logic signed [SPEED_W-1:0] rope_speed_t;

    typedef enum logic {
        FREE    = 1'b0,
        HOLDING = 1'b1
    } grab_state_t;
endpackage

// File: rtl/rope_hit_tracker.sv
// Per-rope wall/monkey hit accumulation with a wall-bounce lockout counter.
// Latency: evaluation results register on the startOfFrame edge (visible next cycle).
// Backpressure: none; pixel-rate inputs are consumed every cycle, no stall.
module rope_hit_tracker #(
    parameter int LOCK_FRAMES = rope_pkg::LOCK_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic ropeDR,
    input  logic monkeyDR,
    input  logic borderDR,
    output logic dirToggle,
    output logic monkeyCollision,
    output logic monkHit
);

    logic       wall_hit;
    logic [3:0] lock_cnt;

    // Accumulate hits during active pixels; the startOfFrame cycle is blanking and starts a new empty frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wall_hit <= 1'b0;
            monkHit  <= 1'b0;
        end else if (startOfFrame) begin
            wall_hit <= 1'b0;
            monkHit  <= 1'b0;
        end else begin
            wall_hit <= wall_hit | (ropeDR & borderDR);
            monkHit  <= monkHit  | (ropeDR & monkeyDR);
        end
    end

    // Frame evaluation: toggle on an unlocked wall hit and arm the lockout, otherwise count the lockout down.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dirToggle       <= 1'b0;
            monkeyCollision <= 1'b0;
            lock_cnt        <= 4'd0;
        end else if (startOfFrame) begin
            monkeyCollision <= monkHit;
            if (wall_hit && (lock_cnt == 4'd0)) begin
                dirToggle <= 1'b1;
                lock_cnt  <= 4'(LOCK_FRAMES);
            end else begin
                dirToggle <= 1'b0;
                if (lock_cnt != 4'd0) begin
                    lock_cnt <= lock_cnt - 4'd1;
                end
            end
        end else begin
            dirToggle <= 1'b0;
        end
    end

endmodule

// File: rtl/rope_collision_controller.sv
// Frame-synchronous rope collision controller: per-rope toggles, monkey collisions, grab select.
// Latency: frame results 1 cycle after startOfFrame; grabSpeed tracks ropeSpeeds 1 cycle late.
// Backpressure: none; all inputs sampled every cycle, outputs are levels/pulses.
module rope_collision_controller #(
    parameter int ROPES       = rope_pkg::ROPES,
    parameter int LOCK_FRAMES = rope_pkg::LOCK_FRAMES,
    parameter int SPEED_W     = rope_pkg::SPEED_W
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [ROPES-1:0]           ropeDR,
    input  logic                       monkeyDR,
    input  logic                       borderDR,
    input  logic [ROPES*SPEED_W-1:0]   ropeSpeeds,
    output logic [ROPES-1:0]           dirToggle,
    output logic [ROPES-1:0]           monkeyCollision,
    output logic                       grabValid,
    output logic [$clog2(ROPES)-1:0]   grabIdx,
    output logic [SPEED_W-1:0]         grabSpeed
);
    import rope_pkg::*;

    localparam int IDX_W = $clog2(ROPES);

    logic [ROPES-1:0]   monk_hit;
    grab_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   low_idx;
    logic               any_hit;
    logic               held_hit;
    logic [SPEED_W-1:0] sel_speed;

    for (genvar i = 0; i < ROPES; i++) begin : g_rope
        rope_hit_tracker #(
            .LOCK_FRAMES(LOCK_FRAMES)
        ) u_trk (
            .clk             (clk),
            .resetN          (resetN),
            .startOfFrame    (startOfFrame),
            .ropeDR          (ropeDR[i]),
            .monkeyDR        (monkeyDR),
            .borderDR        (borderDR),
            .dirToggle       (dirToggle[i]),
            .monkeyCollision (monkeyCollision[i]),
            .monkHit         (monk_hit[i])
        );
    end

    // Lowest-index priority encoder over this frame's monkey hits.
    always_comb begin
        low_idx = '0;
        any_hit = |monk_hit;
        for (int i = ROPES - 1; i >= 0; i--) begin
            if (monk_hit[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    // Select the held rope's hit flag and speed; a pure mux, sign untouched.
    always_comb begin
        held_hit  = 1'b0;
        sel_speed = '0;
        for (int i = 0; i < ROPES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                held_hit  = monk_hit[i];
                sel_speed = ropeSpeeds[i*SPEED_W +: SPEED_W];
            end
        end
    end

    // Grab arbitration at frame start: a still-touched held rope is sticky, otherwise take the lowest hit or release.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (startOfFrame) begin
            if (!((state_q == HOLDING) && held_hit)) begin
                if (any_hit) begin
                    state_d = HOLDING;
                    idx_d   = low_idx;
                end else begin
                    state_d = FREE;
                    idx_d   = '0;
                end
            end
        end
    end

    // Grab state register and registered speed forward (zero while free).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= FREE;
            idx_q     <= '0;
            grabSpeed <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            grabSpeed <= (state_q == HOLDING) ? sel_speed : '0;
        end
    end

    assign grabValid = (state_q == HOLDING);
    assign grabIdx   = idx_q;

endmodule

// File: doc/rope_collision_controller.md
# rope_collision_controller

Frame-synchronous collision controller that closes the loop for the rope display array. Each frame, it watches the per-rope drawing requests against the monkey and wall drawing requests. At start-of-frame it issues per-rope direction-toggle pulses and per-rope monkey-collision levels, and it selects one grabbed rope whose signed speed is forwarded to the monkey mover. It sits between the VGA object layer (rope, monkey and border DR signals) and the rope and monkey movement blocks.

## Interface
Parameters:
- ROPES, 6, number of ropes.
- LOCK_FRAMES, 4, frames a rope ignores further wall hits after a toggle (1..15).
- SPEED_W, 32, width of a signed rope speed.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- ropeDR  in  ROPES  per-rope drawing request for the current pixel.
- monkeyDR  in  1  monkey drawing request for the current pixel.
- borderDR  in  1  side-wall drawing request for the current pixel.
- ropeSpeeds  in  ROPES×SPEED_W  signed current speed of each rope.
- dirToggle  out  ROPES  one-cycle pulse; rope i must reverse direction.
- monkeyCollision  out  ROPES  level; monkey overlapped rope i during the last complete frame.
- grabValid  out  1  monkey holds a rope.
- grabIdx  out  $clog2(ROPES)  index of the held rope.
- grabSpeed  out  SPEED_W  signed speed of the held rope (0 when grabValid=0).

## Operation
- Per-rope accumulators are active in every cycle with startOfFrame=0:
  - wallHit[i] |= ropeDR[i] & borderDR.
  - monkHit[i] |= ropeDR[i] & monkeyDR.
- Pixel inputs in the startOfFrame cycle are discarded, since that cycle is blanking.
- Per-rope lockout counter lock[i] is 4 bits.
- Evaluation on startOfFrame, applied to every rope in parallel:
  - If wallHit[i] & lock[i]==0: pulse dirToggle[i], then set lock[i]=LOCK_FRAMES.
  - Otherwise, if lock[i]!=0, decrement it by 1 and assert no pulse.
  - monkeyCollision[i] <= monkHit[i].
  - Clear wallHit and monkHit in the same edge. The new frame starts empty.
- Grab arbitration (state HOLDING / FREE), evaluated at startOfFrame:
  - HOLDING and monkHit[grabIdx]=1: stay. Sticky; a lower-index hit does not steal the grab.
  - HOLDING and monkHit[grabIdx]=0: if any monkHit, re-grab the lowest set index; else go FREE, grabValid=0, grabIdx=0.
  - FREE and any monkHit: go HOLDING on the lowest set index.
- grabSpeed is a registered copy of ropeSpeeds[grabIdx], updated every cycle while HOLDING, and forced to 0 while FREE.
- No arithmetic on speeds: a pure select, sign preserved.

## Timing
- Reset values: dirToggle=0, monkeyCollision=0, grabValid=0, grabIdx=0, grabSpeed=0, all accumulators and lock counters 0, state FREE.
- startOfFrame sampled high at edge t:
  - dirToggle, monkeyCollision, grabValid and grabIdx take their new values at edge t.
  - They are visible in cycle t+1, i.e. 1-cycle latency.
- dirToggle is high for exactly one cycle per evaluation and is zero in all other cycles.
- grabSpeed follows ropeSpeeds with 1 cycle of latency. After a grab change it reflects the new rope at edge t+1.
- Two startOfFrame pulses back-to-back: the second evaluates empty accumulators. No toggles; monkeyCollision clears; the grab releases.
- Reset asserted mid-frame: all state clears immediately, and partial-frame hits are lost.

## Structure
- Shared package rope_pkg holds:
  - ROPES default and LOCK_FRAMES default.
  - SPEED_W.
  - typedef rope_speed_t (signed [SPEED_W-1:0]).
  - typedef grab_state_t {FREE, HOLDING}.
- One sub-module, rope_hit_tracker, instantiated per rope via generate. It contains the wallHit/monkHit accumulators, the lock counter and the dirToggle/monkeyCollision registers.
- The top level contains the grab FSM, the lowest-index priority encoder and the speed mux.

## Test plan
- Wall hit: rope 2 ropeDR&borderDR for 3 pixels in frame 1 -> at the next startOfFrame, dirToggle=6'b000100 for exactly 1 cycle and no other pulses.
- Lockout: rope 2 hits the wall in frames 1–6, LOCK_FRAMES=4 -> toggles after frame 1 and frame 6 only.
- Grab priority: monkey overlaps ropes 4 and 1 in frame 1 -> grabValid=1, grabIdx=1, grabSpeed=ropeSpeeds[1] (e.g. -40 stays -40).
- Sticky grab: holding rope 1; next frame overlaps ropes 0 and 1 -> grabIdx stays 1. The following frame overlaps only 3 -> grabIdx=3. A frame with no overlap -> grabValid=0, grabSpeed=0.
- Discarded SOF pixel: ropeDR[0]&borderDR only in the startOfFrame cycle -> no dirToggle at that frame end or the next.
- Reset mid-frame: hits accumulated, then resetN low for 1 cycle -> all outputs 0 and the next startOfFrame produces no pulses.
